// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU and buffered load writebacks onto one register-file write port.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_value,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [31:0]                ld_data,
  input  logic [4:0]                 query_addr,
  output logic                       query_pending,
  output logic                       write_regf_en,
  output logic [4:0]                 addr_rd,
  output logic [31:0]                rd_value,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       mem_rd  [DEPTH];
  logic [31:0]      mem_val [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rptr, wptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;
  logic             empty, full, enq, deq, alu_req, force_ld, grant_alu, hit;
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign ld_ready   = !full;
  assign fifo_count = count;
  assign alu_req    = alu_valid && alu_rd != '0;
  assign force_ld   = starve == SW'(STARVE_LIMIT) && !empty;
  assign deq        = force_ld || (!alu_req && !empty);
  assign grant_alu  = !force_ld && alu_req;
  assign alu_ready  = !force_ld;
  assign enq        = ld_valid && !full && ld_rd != '0;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (vld[i] && mem_rd[i] == query_addr);
    query_pending = hit && query_addr != '0;
  end
  always_ff @(posedge clk)
    if (enq) begin
      mem_rd[wptr]  <= ld_rd;
      mem_val[wptr] <= ld_data;
    end
  // enq and deq never hit the same slot: deq needs non-empty, enq needs non-full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr          <= '0;
      wptr          <= '0;
      count         <= '0;
      vld           <= '0;
      starve        <= '0;
      write_regf_en <= 1'b0;
      addr_rd       <= '0;
      rd_value      <= '0;
    end else begin
      if (enq) begin
        wptr      <= wptr + 1'b1;
        vld[wptr] <= 1'b1;
      end
      if (deq) begin
        rptr      <= rptr + 1'b1;
        vld[rptr] <= 1'b0;
      end
      count         <= count + CW'(enq) - CW'(deq);
      starve        <= (empty || deq) ? '0 :
                       (grant_alu && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
      write_regf_en <= deq || grant_alu;
      if (deq) begin
        addr_rd  <= mem_rd[rptr];
        rd_value <= mem_val[rptr];
      end else if (grant_alu) begin
        addr_rd  <= alu_rd;
        rd_value <= alu_value;
      end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed stimulus with a queue-based reference model checked every cycle.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 3;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, ld_valid = 0;
  logic [4:0] alu_rd = 0, ld_rd = 0, query_addr = 0;
  logic [31:0] alu_value = 0, ld_data = 0;
  logic alu_ready, ld_ready, query_pending, write_regf_en;
  logic [4:0] addr_rd;
  logic [31:0] rd_value;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .query_addr(query_addr), .query_pending(query_pending),
    .write_regf_en(write_regf_en), .addr_rd(addr_rd), .rd_value(rd_value),
    .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [4:0] rd; logic [31:0] v; } ent_t;
  ent_t q[$];
  int m_st = 0;
  logic m_we = 0, m_force, m_qp, m_areq, m_enq;
  logic [4:0] m_addr = 0;
  logic [31:0] m_val = 0;

  // Inputs only change shortly after posedge, so the negedge sees the values the next edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_st = 0; m_we = 0; m_addr = 0; m_val = 0;
    end
    m_force = m_st == STARVE_LIMIT && q.size() > 0;
    m_qp = 0;
    foreach (q[i]) if (q[i].rd == query_addr) m_qp = 1;
    if (query_addr == 0) m_qp = 0;
    chk("m_alu_ready", alu_ready, !m_force);
    chk("m_ld_ready", ld_ready, q.size() != DEPTH);
    chk("m_query_pending", query_pending, m_qp);
    chk("m_fifo_count", fifo_count, q.size());
    chk("m_write_en", write_regf_en, m_we);
    chk("m_addr_rd", addr_rd, m_addr);
    chk("m_rd_value", rd_value, m_val);
    if (rst_n) begin
      m_areq = alu_valid && alu_rd != 0;
      m_enq = ld_valid && q.size() != DEPTH && ld_rd != 0;
      if (m_force || (!m_areq && q.size() > 0)) begin
        m_we = 1; m_addr = q[0].rd; m_val = q[0].v; m_st = 0;
        void'(q.pop_front());
      end else if (m_areq) begin
        m_we = 1; m_addr = alu_rd; m_val = alu_value;
        m_st = q.size() > 0 ? (m_st < STARVE_LIMIT ? m_st + 1 : m_st) : 0;
      end else begin
        m_we = 0; m_st = 0;
      end
      if (m_enq) q.push_back('{ld_rd, ld_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int exp2 [17] = '{9,9,9,9,1,9,9,9,2,9,9,9,3,9,9,9,4};

  initial begin
    repeat (2) tick();
    chk("rst_we", write_regf_en, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_qp", query_pending, 0);
    rst_n = 1;
    tick();
    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_value = 32'h11;
    #1 chk("t1_alu_ready", alu_ready, 1);
    tick();
    chk("t1_we", write_regf_en, 1);
    chk("t1_addr", addr_rd, 5);
    chk("t1_val", rd_value, 32'h11);
    // starvation guard interleaving
    alu_rd = 9; alu_value = 32'h99;
    for (int i = 0; i < 17; i++) begin
      ld_valid = i < 4; ld_rd = 5'(i + 1); ld_data = 32'h100 + i + 1;
      tick();
      chk("t2_we", write_regf_en, 1);
      chk("t2_addr", addr_rd, exp2[i]);
    end
    chk("t2_val_last", rd_value, 32'h104);
    chk("t2_count", fifo_count, 0);
    // fill to full, offer load during forced dequeue
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'h200 + i;
      tick();
    end
    chk("t3_count_full", fifo_count, 4);
    ld_rd = 14; ld_data = 32'h20e;
    #1 chk("t3_ld_ready_full", ld_ready, 0);
    chk("t3_alu_blocked", alu_ready, 0);
    tick();
    chk("t3_count_after_deq", fifo_count, 3);
    chk("t3_forced_addr", addr_rd, 10);
    tick();
    chk("t3_count_refill", fifo_count, 4);
    chk("t3_alu_addr", addr_rd, 9);
    ld_valid = 0; alu_valid = 0;
    repeat (4) tick();
    chk("t3_drain_count", fifo_count, 0);
    chk("t3_drain_addr", addr_rd, 14);
    chk("t3_drain_val", rd_value, 32'h20e);
    // pending lookup
    alu_valid = 1; alu_rd = 9; ld_valid = 1; ld_rd = 7; ld_data = 32'h77; query_addr = 7;
    tick();
    ld_valid = 0;
    chk("t4_qp_1", query_pending, 1);
    query_addr = 0;
    #1 chk("t4_qp_zero", query_pending, 0);
    query_addr = 7;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("t4_qp_held", query_pending, 1);
    end
    chk("t4_force", alu_ready, 0);
    tick();
    chk("t4_qp_clear", query_pending, 0);
    chk("t4_addr", addr_rd, 7);
    alu_valid = 0; query_addr = 0;
    tick();
    // zero-destination requests
    alu_valid = 1; alu_rd = 0; alu_value = 32'hdead; ld_valid = 1; ld_rd = 0; ld_data = 32'hbeef;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_alu_ready", alu_ready, 1);
      chk("t5_ld_ready", ld_ready, 1);
      tick();
      chk("t5_we", write_regf_en, 0);
      chk("t5_count", fifo_count, 0);
    end
    // async reset with queued entries
    alu_rd = 9; alu_value = 32'h99;
    for (int i = 0; i < 3; i++) begin
      ld_rd = 5'(20 + i); ld_data = 32'h300 + i;
      tick();
    end
    chk("t6_count_pre", fifo_count, 3);
    #1 rst_n = 0;
    alu_valid = 0; ld_valid = 0;
    #1 chk("t6_we_async", write_regf_en, 0);
    chk("t6_count_async", fifo_count, 0);
    chk("t6_addr_async", addr_rd, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_stale", write_regf_en, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side front end for the register-file write port: merges the ALU writeback stream and the load-unit writeback stream onto the single port (write_regf_en / addr_rd / rd_value).
- Load results are buffered in a small FIFO.
- ALU results have priority, with a starvation guard that forces a load grant.
- Provides a pending-write lookup so the hazard unit can stall readers of registers with queued load results.

Parameters:
- DEPTH, 4, load FIFO entries (power of two, >= 2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty load FIFO may lose to the ALU before a forced load grant (>= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_rd  input  5  ALU destination register.
- alu_value  input  32  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  FIFO can accept a load result.
- ld_rd  input  5  load destination register.
- ld_data  input  32  load data.
- query_addr  input  5  register address probed by the hazard unit.
- query_pending  output  1  some FIFO entry targets query_addr.
- write_regf_en  output  1  register-file write enable.
- addr_rd  output  5  register-file write address.
- rd_value  output  32  register-file write data.
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low (rst_n).
  - While rst_n = 0: write_regf_en = 0, addr_rd = 0, rd_value = 0, FIFO empty (fifo_count = 0), starve counter = 0.
  - Consequently ld_ready = 1, alu_ready = 1 and query_pending = 0 during reset.
- Reset mid-operation discards all queued entries; no write is issued for them.
- ld_ready = (fifo_count != DEPTH), computed from the registered count only.
  - When full, there is no enqueue even if a dequeue happens in the same cycle.
- A load is enqueued when ld_valid && ld_ready.
  - Loads with ld_rd == 0 are accepted (handshake completes) but not stored.
- The ALU request is dropped silently when alu_rd == 0 (alu_ready = 1, no write).
- Grant (combinational, per cycle):
  - force = (starve_cnt == STARVE_LIMIT) && fifo non-empty.
  - If force: load head granted, alu_ready = 0 (ALU holds its request).
  - Else if alu_valid with alu_rd != 0: ALU granted, alu_ready = 1.
  - Else if fifo non-empty: load head granted (dequeued).
  - Else: no write.
- Starve counter:
  - Increments when the FIFO is non-empty and the ALU is granted.
  - Clears on any load grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output register: the granted {1, rd, value} is registered, so the write appears 1 cycle after the grant.
  - With no grant, write_regf_en <= 0; addr_rd and rd_value hold their last values.
- FIFO:
  - Circular read/write pointers that wrap modulo DEPTH.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - An empty FIFO can accept and hold an entry in the same cycle, but the entry is not granted until the next cycle (no fall-through).
- query_pending:
  - Combinational OR over valid FIFO entries with rd == query_addr.
  - query_addr == 0 always gives 0.
  - The entry being dequeued still counts in its grant cycle.
- Ordering:
  - Loads retire in FIFO order.
  - Relative order between ALU and load writes to the same rd is not guaranteed; the hazard unit must use query_pending.
- Every write_regf_en pulse has addr_rd != 0.

Test Plan:
1. Reset, then ALU req rd=5 value=0x11 -> next cycle write_regf_en=1, addr_rd=5, rd_value=0x11; alu_ready=1.
2. Four loads rd=1..4 with alu_valid held high (rd=9, STARVE_LIMIT=3) -> ALU wins 3 cycles, then alu_ready=0 and rd=1 is written; pattern repeats until all 4 loads retire in order.
3. Fill FIFO to DEPTH=4 while ALU blocks → ld_ready=0; offer load with simultaneous forced dequeue -> not accepted; fifo_count stays 3 after the dequeue, then 4 the next cycle once the load is accepted.
4. Enqueue rd=7; query_addr=7 -> query_pending=1 until the cycle its write is granted inclusive, then 0; query_addr=0 -> 0 throughout.
5. ALU rd=0 and load rd=0 -> both handshakes complete, write_regf_en never asserts, fifo_count stays 0.
6. rst_n low asynchronously with 3 entries queued -> write_regf_en=0 immediately, fifo_count=0; after release no stale writes appear.
